// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment scanner with a double-buffered frame and ghost-blanking gaps.
// Optional leading-zero suppression at frame copy: define SEVSEG_LZ_SUPPRESS_EN.
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      DRV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

  typedef enum logic {S_DRIVE, S_GAP} state_t;

  // Logical segment pattern, bit order g..a, active high.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

`ifdef SEVSEG_LZ_SUPPRESS_EN
  // Blank zero digits above digit 0 while every higher digit is zero or disabled.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] val,
                                                    input logic [NUM_DIGITS-1:0]   en);
    logic [NUM_DIGITS-1:0] m;
    logic                  lead;
    m    = en;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && (val[4*i +: 4] == 4'h0)) m[i] = 1'b0;
      lead = lead && ((val[4*i +: 4] == 4'h0) || !en[i]);
    end
    return m;
  endfunction
`endif

  state_t                  state_q, state_d;
  logic                    run_q, run_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_next;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, frame_val_q, frame_val_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, frame_en_q, frame_en_d;
  logic [6:0]              seg_q, seg_d, seg_log;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d, sel_log;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_copy;

  always_comb begin
    run_d    = 1'b1;
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // First edge after reset enters digit 0 cleanly, so slot 0 gets its full dwell.
    if (!run_q) begin
      state_d = S_DRIVE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_DRIVE) begin
      if (cnt_q == DRV_LAST) begin
        cnt_d = '0;
        if (BLANK_CYCLES > 0) state_d = S_GAP;
        else                  idx_d   = idx_next;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = S_DRIVE;
        idx_d   = idx_next;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // cnt is zero in DRIVE only on the entry cycle, so this marks the frame boundary.
    frame_copy = (state_d == S_DRIVE) && (idx_d == '0) && (cnt_d == '0);

    pend_val_d  = load ? value : pend_val_q;
    pend_en_d   = load ? digit_en : pend_en_q;
    frame_val_d = frame_copy ? pend_val_d : frame_val_q;
`ifdef SEVSEG_LZ_SUPPRESS_EN
    frame_en_d  = frame_copy ? lz_mask(pend_val_d, pend_en_d) : frame_en_q;
`else
    frame_en_d  = frame_copy ? pend_en_d : frame_en_q;
`endif

    seg_log = '0;
    sel_log = '0;
    if (state_d == S_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          sel_log[i] = 1'b1;
          if (frame_en_d[i]) seg_log = decode(frame_val_d[4*i +: 4]);
        end
      end
    end

    seg_d         = seg_log ^ SEG_OFF;
    digit_sel_d   = sel_log ^ DIG_OFF;
    frame_start_d = frame_copy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_DRIVE;
      run_q         <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      pend_val_q    <= '0;
      pend_en_q     <= '0;
      frame_val_q   <= '0;
      frame_en_q    <= '0;
      seg_q         <= SEG_OFF;
      digit_sel_q   <= DIG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pend_val_q    <= pend_val_d;
      pend_en_q     <= pend_en_d;
      frame_val_q   <= frame_val_d;
      frame_en_q    <= frame_en_d;
      seg_q         <= seg_d;
      digit_sel_q   <= digit_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule
